// File: rtl/icache_axi3_linefill.sv
// Instruction-cache line-fill engine: one AXI3 read burst per miss,
// critical word forwarded early, full line delivered on completion.
module icache_axi3_linefill #(
   parameter int          ADDR_SIZE  = 32,
   parameter int          DATA_SIZE  = 32,
   parameter int          BLOCK_SIZE = 32,
   parameter logic [3:0]  AXI_ID     = 4'h0,
   parameter bit          WRAP       = 1'b1
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [ADDR_SIZE-1:0]    req_addr,
   input  logic                    flush,
   output logic [3:0]              ARID,
   output logic [ADDR_SIZE-1:0]    ARADDR,
   output logic [3:0]              ARLEN,
   output logic [2:0]              ARSIZE,
   output logic [1:0]              ARBURST,
   output logic                    ARVALID,
   input  logic                    AXI_ARREADY,
   input  logic [3:0]              AXI_RID,
   input  logic [DATA_SIZE-1:0]    AXI_RDATA,
   input  logic [1:0]              AXI_RRESP,
   input  logic                    AXI_RLAST,
   input  logic                    AXI_RVALID,
   output logic                    RREADY,
   output logic                    cw_valid,
   output logic [DATA_SIZE-1:0]    cw_data,
   output logic                    line_valid,
   output logic [BLOCK_SIZE*8-1:0] line_data,
   output logic                    line_err
);

   localparam int BEATS = BLOCK_SIZE * 8 / DATA_SIZE;
   localparam int IW    = $clog2(BEATS);
   localparam int BOFF  = $clog2(DATA_SIZE / 8);

   localparam logic [ADDR_SIZE-1:0] WMASK = ADDR_SIZE'(DATA_SIZE / 8 - 1);
   localparam logic [ADDR_SIZE-1:0] LMASK = ADDR_SIZE'(BLOCK_SIZE - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ADDR  = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]              state;
   logic [ADDR_SIZE-1:0]    addr_q;
   logic [IW-1:0]           cnt;
   logic [IW-1:0]           crit_idx;
   logic [IW-1:0]           widx;
   logic                    err;
   logic                    flush_pend;
   logic [BLOCK_SIZE*8-1:0] line_q;
   logic                    beat;
   logic                    last_cnt;
   logic                    fin;
   logic                    bad_last;
   logic                    unused_ok;

   assign unused_ok = AXI_RRESP[0];

   assign crit_idx = addr_q[BOFF +: IW];
   // IW-bit add wraps modulo BEATS since BEATS is a power of two
   assign widx     = WRAP ? IW'(crit_idx + cnt) : cnt;
   assign beat     = AXI_RVALID && RREADY && (AXI_RID == AXI_ID);
   assign last_cnt = (cnt == IW'(BEATS - 1));
   assign fin      = AXI_RLAST || last_cnt;
   assign bad_last = AXI_RLAST != last_cnt;

   assign req_ready  = (state == S_IDLE);
   assign ARVALID    = (state == S_ADDR);
   assign RREADY     = (state == S_DATA) || (state == S_DRAIN);
   assign ARID       = AXI_ID;
   assign ARLEN      = 4'(BEATS - 1);
   assign ARSIZE     = 3'(BOFF);
   assign ARBURST    = WRAP ? 2'b10 : 2'b01;
   assign ARADDR     = addr_q & ~(WRAP ? WMASK : LMASK);
   assign line_valid = (state == S_DONE);
   assign line_err   = (state == S_DONE) && err;
   assign line_data  = line_q;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state      <= S_IDLE;
         addr_q     <= '0;
         cnt        <= '0;
         err        <= 1'b0;
         flush_pend <= 1'b0;
         line_q     <= '0;
         cw_valid   <= 1'b0;
         cw_data    <= '0;
      end else begin
         cw_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  addr_q     <= req_addr;
                  cnt        <= '0;
                  err        <= 1'b0;
                  flush_pend <= 1'b0;
                  state      <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (flush)
                  flush_pend <= 1'b1;
               // AR stays up even when flushed; its burst must still drain
               if (AXI_ARREADY)
                  state <= (flush || flush_pend) ? S_DRAIN : S_DATA;
            end
            S_DATA: begin
               if (flush) begin
                  state <= (beat && AXI_RLAST) ? S_IDLE : S_DRAIN;
               end else if (beat) begin
                  line_q[widx*DATA_SIZE +: DATA_SIZE] <= AXI_RDATA;
                  cnt <= cnt + 1'b1;
                  if (AXI_RRESP[1] || bad_last)
                     err <= 1'b1;
                  if (widx == crit_idx) begin
                     cw_valid <= 1'b1;
                     cw_data  <= AXI_RDATA;
                  end
                  if (fin)
                     state <= S_DONE;
               end
            end
            S_DRAIN: begin
               if (beat && AXI_RLAST)
                  state <= S_IDLE;
            end
            S_DONE: begin
               err   <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_axi3_linefill.sv
// Bench for icache_axi3_linefill: a WRAP and an INCR instance share one
// AXI slave stimulus and are checked against a per-fill reference model.
module tb_icache_axi3_linefill;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        flush;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;

   logic         req_ready[2];
   logic [3:0]   arid[2];
   logic [31:0]  araddr[2];
   logic [3:0]   arlen[2];
   logic [2:0]   arsize[2];
   logic [1:0]   arburst[2];
   logic         arvalid[2];
   logic         rready[2];
   logic         cw_valid[2];
   logic [31:0]  cw_data[2];
   logic         line_valid[2];
   logic [255:0] line_data[2];
   logic         line_err[2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   icache_axi3_linefill #(.WRAP(1'b1)) u_wrap (
      .ACLK(clk), .ARESET(rst),
      .req_valid(req_valid), .req_ready(req_ready[0]),
      .req_addr(req_addr), .flush(flush),
      .ARID(arid[0]), .ARADDR(araddr[0]), .ARLEN(arlen[0]),
      .ARSIZE(arsize[0]), .ARBURST(arburst[0]), .ARVALID(arvalid[0]),
      .AXI_ARREADY(arready),
      .AXI_RID(rid), .AXI_RDATA(rdata), .AXI_RRESP(rresp),
      .AXI_RLAST(rlast), .AXI_RVALID(rvalid), .RREADY(rready[0]),
      .cw_valid(cw_valid[0]), .cw_data(cw_data[0]),
      .line_valid(line_valid[0]), .line_data(line_data[0]),
      .line_err(line_err[0])
   );

   icache_axi3_linefill #(.WRAP(1'b0)) u_incr (
      .ACLK(clk), .ARESET(rst),
      .req_valid(req_valid), .req_ready(req_ready[1]),
      .req_addr(req_addr), .flush(flush),
      .ARID(arid[1]), .ARADDR(araddr[1]), .ARLEN(arlen[1]),
      .ARSIZE(arsize[1]), .ARBURST(arburst[1]), .ARVALID(arvalid[1]),
      .AXI_ARREADY(arready),
      .AXI_RID(rid), .AXI_RDATA(rdata), .AXI_RRESP(rresp),
      .AXI_RLAST(rlast), .AXI_RVALID(rvalid), .RREADY(rready[1]),
      .cw_valid(cw_valid[1]), .cw_data(cw_data[1]),
      .line_valid(line_valid[1]), .line_data(line_data[1]),
      .line_err(line_err[1])
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // flush_at: -2 none, -1 during AR phase, k>=0 after k beats.
   // last_pos: beat carrying RLAST; >7 means RLAST never sent.
   task automatic do_fill(input logic [31:0] addr, input int ar_delay,
                          input int err_beat, input int last_pos,
                          input int flush_at, input int foreign_at,
                          input bit gaps);
      logic [31:0] dat[8];
      logic [31:0] exp_addr[2];
      logic [1:0]  exp_burst[2];
      logic [31:0] mline[2][8];
      bit          mset[2][8];
      bit          merr[2];
      bit          ecw[2];
      logic [31:0] ecwd[2];
      bit          elv[2];
      bit          drain;
      bit          fdone;
      int          nb;
      int          k;
      int          crit;
      int          w;
      crit = int'(addr[4:2]);
      nb = (last_pos > 7) ? 8 : last_pos + 1;
      exp_addr[0] = addr & ~32'h3;
      exp_addr[1] = addr & ~32'h1f;
      exp_burst[0] = 2'b10;
      exp_burst[1] = 2'b01;
      for (int i = 0; i < 8; i++) dat[i] = $urandom;
      for (int d = 0; d < 2; d++) begin
         merr[d] = 1'b0; ecw[d] = 1'b0; elv[d] = 1'b0; ecwd[d] = '0;
         for (int i = 0; i < 8; i++) begin
            mset[d][i] = 1'b0; mline[d][i] = '0;
         end
      end
      // a flush while idle must not disturb the next request
      @(negedge clk);
      flush = 1'($urandom % 2);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (req_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready dut%0d: got %b want 1", d, req_ready[d]);
         end
      end
      @(negedge clk);
      flush = 1'b0; req_valid = 1'b1; req_addr = addr;
      @(negedge clk);
      req_valid = 1'b0;
      drain = (flush_at == -1);
      for (int c = 0; c <= ar_delay; c++) begin
         for (int d = 0; d < 2; d++) begin
            checks++;
            if ({arvalid[d], araddr[d], arlen[d], arsize[d], arburst[d],
                 arid[d], rready[d], req_ready[d]} !==
                {1'b1, exp_addr[d], 4'd7, 3'd2, exp_burst[d],
                 4'h0, 1'b0, 1'b0}) begin
               errors++;
               $display("FAIL ar_phase dut%0d cyc%0d: got v=%b a=%h len=%0d sz=%0d b=%0d id=%0d rr=%b rq=%b want a=%h b=%0d",
                        d, c, arvalid[d], araddr[d], arlen[d], arsize[d],
                        arburst[d], arid[d], rready[d], req_ready[d],
                        exp_addr[d], exp_burst[d]);
            end
         end
         flush = drain && (c == 0);
         arready = (c == ar_delay);
         @(negedge clk);
      end
      arready = 1'b0; flush = 1'b0;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({arvalid[d], rready[d]} !== 2'b01) begin
            errors++;
            $display("FAIL data_entry dut%0d: got arvalid=%b rready=%b want 0 1",
                     d, arvalid[d], rready[d]);
         end
      end
      k = 0; fdone = 1'b0;
      while (1) begin
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (cw_valid[d] !== ecw[d]) begin
               errors++;
               $display("FAIL cw_valid dut%0d: got %b want %b", d, cw_valid[d], ecw[d]);
            end
            if (ecw[d]) begin
               checks++;
               if (cw_data[d] !== ecwd[d]) begin
                  errors++;
                  $display("FAIL cw_data dut%0d: got %h want %h", d, cw_data[d], ecwd[d]);
               end
            end
            checks++;
            if (line_valid[d] !== elv[d]) begin
               errors++;
               $display("FAIL line_valid dut%0d: got %b want %b", d, line_valid[d], elv[d]);
            end
            if (elv[d]) begin
               checks++;
               if (line_err[d] !== merr[d]) begin
                  errors++;
                  $display("FAIL line_err dut%0d: got %b want %b", d, line_err[d], merr[d]);
               end
               for (int i = 0; i < 8; i++) begin
                  if (mset[d][i]) begin
                     checks++;
                     if (line_data[d][i*32 +: 32] !== mline[d][i]) begin
                        errors++;
                        $display("FAIL line_word dut%0d w%0d: got %h want %h",
                                 d, i, line_data[d][i*32 +: 32], mline[d][i]);
                     end
                  end
               end
            end
            checks++;
            if (rready[d] !== (k < nb)) begin
               errors++;
               $display("FAIL rready dut%0d: got %b want %b", d, rready[d], k < nb);
            end
         end
         if (k >= nb) break;
         flush = 1'b0;
         for (int d = 0; d < 2; d++) begin
            ecw[d] = 1'b0; elv[d] = 1'b0;
         end
         if (gaps && ($urandom % 3 == 0)) begin
            rvalid = 1'b0; rdata = $urandom; rlast = 1'($urandom % 2);
         end else if (flush_at == k && !drain) begin
            rvalid = 1'b0; flush = 1'b1; drain = 1'b1;
         end else if (foreign_at == k && !fdone) begin
            rvalid = 1'b1; rid = 4'h5; rdata = $urandom;
            rresp = 2'b00; rlast = 1'b1; fdone = 1'b1;
         end else begin
            rvalid = 1'b1; rid = 4'h0; rdata = dat[k];
            rresp = (k == err_beat) ? 2'b10 : {1'b0, 1'($urandom % 2)};
            rlast = (k == last_pos);
            if (!drain) begin
               for (int d = 0; d < 2; d++) begin
                  w = (d == 0) ? (crit + k) % 8 : k;
                  mline[d][w] = dat[k];
                  mset[d][w] = 1'b1;
                  if (rresp[1] || (rlast != (k == 7))) merr[d] = 1'b1;
                  if (w == crit) begin
                     ecw[d] = 1'b1; ecwd[d] = dat[k];
                  end
                  elv[d] = rlast || (k == 7);
               end
            end
            k++;
         end
         @(negedge clk);
      end
      rvalid = 1'b0; flush = 1'b0; rlast = 1'b0;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (req_ready[d] !== drain) begin
            errors++;
            $display("FAIL end_ready dut%0d: got %b want %b", d, req_ready[d], drain);
         end
      end
      if (!drain) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if ({req_ready[d], line_valid[d], cw_valid[d]} !== 3'b100) begin
               errors++;
               $display("FAIL post_done dut%0d: got ready=%b lv=%b cw=%b want 1 0 0",
                        d, req_ready[d], line_valid[d], cw_valid[d]);
            end
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({req_ready[d], arvalid[d], rready[d], cw_valid[d], line_valid[d],
              line_err[d], line_data[d]} !== {1'b1, 5'b0, 256'b0}) begin
            errors++;
            $display("FAIL reset dut%0d: got ready=%b arv=%b rr=%b cw=%b lv=%b le=%b ld=%h",
                     d, req_ready[d], arvalid[d], rready[d], cw_valid[d],
                     line_valid[d], line_err[d], line_data[d]);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_wrap_basic;
      do_fill(32'h1000_0014, 0, -1, 7, -2, -1, 1'b0);
   endtask

   task automatic test_ar_stall;
      do_fill(32'h2345_6788, 5, -1, 7, -2, -1, 1'b0);
   endtask

   task automatic test_errors;
      do_fill(32'h1000_0014, 1, 3, 7, -2, -1, 1'b0);
      do_fill(32'h1000_0014, 0, -1, 5, -2, -1, 1'b0);
      do_fill(32'h0000_0ffc, 0, -1, 8, -2, -1, 1'b0);
   endtask

   task automatic test_flush;
      do_fill(32'h1000_0014, 0, -1, 7, 2, -1, 1'b0);
      do_fill(32'h3000_0008, 3, -1, 7, -1, -1, 1'b0);
   endtask

   task automatic test_foreign;
      do_fill(32'h1000_0014, 0, -1, 7, -2, 3, 1'b0);
   endtask

   task automatic test_random;
      int mode;
      for (int i = 0; i < 16; i++) begin
         mode = int'($urandom % 5);
         case (mode)
            1: do_fill($urandom, int'($urandom % 4), int'($urandom % 8), 7, -2, -1, 1'b1);
            2: do_fill($urandom, int'($urandom % 4), -1, int'($urandom % 7), -2, -1, 1'b1);
            3: do_fill($urandom, int'($urandom % 4), -1, 7, int'($urandom % 8), -1, 1'b1);
            4: do_fill($urandom, int'($urandom % 4), -1, 7, -2, int'($urandom % 8), 1'b1);
            default: do_fill($urandom, int'($urandom % 4), -1, 7, -2, -1, 1'b1);
         endcase
      end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h4000_0010;
      @(negedge clk);
      req_valid = 1'b0; arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      for (int b = 0; b < 3; b++) begin
         rvalid = 1'b1; rid = 4'h0; rdata = $urandom; rresp = 2'b00; rlast = 1'b0;
         @(negedge clk);
      end
      rvalid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({req_ready[d], arvalid[d], rready[d], cw_valid[d], line_valid[d],
              line_err[d], line_data[d]} !== {1'b1, 5'b0, 256'b0}) begin
            errors++;
            $display("FAIL reset_mid dut%0d: got ready=%b arv=%b rr=%b cw=%b lv=%b le=%b",
                     d, req_ready[d], arvalid[d], rready[d], cw_valid[d],
                     line_valid[d], line_err[d]);
         end
      end
      do_fill(32'h4000_0010, 1, -1, 7, -2, -1, 1'b0);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
      arready = 1'b0; rid = '0; rdata = '0; rresp = '0;
      rlast = 1'b0; rvalid = 1'b0;
      test_reset();
      test_wrap_basic();
      test_ar_stall();
      test_errors();
      test_flush();
      test_foreign();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
